// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: pipeline has priority over the loader/debug port.
// Optional starvation relief is enabled by defining MEM_PORT_ARBITER_FAIRNESS_EN.
//
// state  | meaning
// IDLE   | no access issued last cycle
// PIPE   | pipeline was granted last cycle
// LOAD   | loader was granted normally last cycle
// FORCED | loader was granted last cycle because it had starved
module mem_port_arbiter #(
  parameter int AW           = 9,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_req,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_addr,
  input  logic [DW-1:0] pipe_wdata,
  output logic          pipe_stall,
  output logic          pipe_rvalid,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, PIPE, LOAD, FORCED} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_PIPE, OWN_LD} owner_t;

  state_t state;
  owner_t rd_owner;
  logic   pipe_win;
  logic   ld_win;
  logic   force_ld;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_limit_check
    $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
  end

`ifdef MEM_PORT_ARBITER_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  // A forced grant is never followed by another; the pipeline gets the next contended slot.
  assign force_ld = pipe_req && ld_req && (starve_cnt == LIMIT) && (state != FORCED);

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (ld_req && !ld_win) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  assign force_ld = 1'b0;
`endif

  // Grants are gated by reset so nothing reaches the RAM while rst is low.
  always_comb begin
    ld_win   = 1'b0;
    pipe_win = 1'b0;
    if (rst) begin
      ld_win   = ld_req && (!pipe_req || force_ld);
      pipe_win = pipe_req && !ld_win;
    end
  end

  assign ld_gnt     = ld_win;
  assign pipe_stall = pipe_req && ld_win;
  assign ram_we     = pipe_win ? pipe_we : (ld_win ? ld_we : 1'b0);
  assign ram_addr   = ld_win ? ld_addr : pipe_addr;
  assign ram_wdata  = ld_win ? ld_wdata : pipe_wdata;

  assign pipe_rvalid = rst && (rd_owner == OWN_PIPE);
  assign ld_rvalid   = rst && (rd_owner == OWN_LD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      rd_owner <= OWN_NONE;
    end else begin
      if (pipe_win) begin
        state <= PIPE;
      end else if (ld_win && force_ld) begin
        state <= FORCED;
      end else if (ld_win) begin
        state <= LOAD;
      end else begin
        state <= IDLE;
      end

      if (pipe_win && !pipe_we) begin
        rd_owner <= OWN_PIPE;
      end else if (ld_win && !ld_we) begin
        rd_owner <= OWN_LD;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

endmodule
